// File: rtl/td4_uart_prog_loader_if.sv
// Signal bundle between the UART program loader and the TD4 core it feeds:
// serial/reload inputs plus the program image and load status.
interface td4_uart_prog_loader_if;
    logic         RXD;
    logic         LOAD_REQ;
    logic [127:0] MEM;
    logic         CPU_RSTN;
    logic         BUSY;
    logic         DONE;
    logic         FRAME_ERR;
    logic         CHK_ERR;
    logic [4:0]   PTR;

    modport master (
        input  RXD, LOAD_REQ,
        output MEM, CPU_RSTN, BUSY, DONE, FRAME_ERR, CHK_ERR, PTR
    );

    modport slave (
        output RXD, LOAD_REQ,
        input  MEM, CPU_RSTN, BUSY, DONE, FRAME_ERR, CHK_ERR, PTR
    );
endinterface

// File: rtl/td4_uart_prog_loader.sv
// Loads a 16-byte TD4 program plus checksum over UART 8N1 and keeps the core
// in reset until an image whose bytes and checksum sum to zero is in place.
module td4_uart_prog_loader #(
    parameter int BAUD_DIV = 434
) (
    input logic                    CLK,
    input logic                    RST,
    td4_uart_prog_loader_if.master bus
);
    localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);
    localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ST_LOADING, ST_RUN, ST_ERROR} state_t;

    logic         rxd_s1, rxd_s2, rxd_prev;
    logic         lr_s1, lr_s2, lr_prev;
    logic         lr_edge, rx_fall;
    rx_state_t    rx_state, rx_next;
    logic [15:0]  rx_cnt;
    logic [2:0]   rx_bit;
    logic [7:0]   rx_shift;
    logic         tick, byte_ok, stop_bad;
    state_t       state, next_state;
    logic [127:0] mem;
    logic [4:0]   ptr;
    logic [7:0]   sum, sum_next;
    logic         accept, frame_err;
    logic         cpu_rstn_q, busy_q, done_q, chk_err_q;
    logic         cpu_rstn_d, busy_d, done_d, chk_err_d;

    // RXD idles high, so its synchroniser resets high to avoid a false start edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            lr_s1    <= 1'b0;
            lr_s2    <= 1'b0;
            lr_prev  <= 1'b0;
        end else begin
            rxd_s1   <= bus.RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            lr_s1    <= bus.LOAD_REQ;
            lr_s2    <= lr_s1;
            lr_prev  <= lr_s2;
        end
    end

    assign lr_edge  = lr_s2 & ~lr_prev;
    assign rx_fall  = rxd_prev & ~rxd_s2;
    assign tick     = (rx_cnt == 16'd1);
    assign byte_ok  = (rx_state == RX_STOP) && tick && rxd_s2;
    assign stop_bad = (rx_state == RX_STOP) && tick && !rxd_s2;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rx_state <= RX_IDLE;
        else      rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (tick) rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timer: half a bit to the start-bit centre, then a full bit per sample
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            if (rx_state == RX_IDLE) begin
                if (rx_fall) rx_cnt <= HALF_BIT;
            end else if (tick) begin
                rx_cnt <= FULL_BIT;
            end else begin
                rx_cnt <= rx_cnt - 16'd1;
            end
            if (rx_state == RX_START && tick) rx_bit <= 3'd0;
            if (rx_state == RX_DATA && tick) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rxd_s2, rx_shift[7:1]};
            end
        end
    end

    assign sum_next = sum + rx_shift;
    assign accept   = (state == ST_LOADING) && byte_ok && !lr_edge;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_LOADING;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (lr_edge)
            next_state = ST_LOADING;
        else if (accept && ptr == 5'd16)
            next_state = (sum_next == 8'd0) ? ST_RUN : ST_ERROR;
    end

    // Status outputs are derived from the next state and registered, so
    // CPU_RSTN changes in the same cycle as the state and never glitches
    always_comb begin
        cpu_rstn_d = (next_state == ST_RUN);
        busy_d     = (next_state == ST_LOADING);
        chk_err_d  = (next_state == ST_ERROR);
        done_d     = (state == ST_LOADING) && (next_state == ST_RUN);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            chk_err_q  <= 1'b0;
        end else begin
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            chk_err_q  <= chk_err_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem       <= 128'd0;
            ptr       <= 5'd0;
            sum       <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            if (lr_edge) begin
                ptr <= 5'd0;
                sum <= 8'd0;
            end else if (accept && ptr != 5'd16) begin
                mem[{ptr[3:0], 3'b000} +: 8] <= rx_shift;
                sum <= sum_next;
                ptr <= ptr + 5'd1;
            end
            if (lr_edge)       frame_err <= 1'b0;
            else if (stop_bad) frame_err <= 1'b1;
        end
    end

    assign bus.MEM       = mem;
    assign bus.PTR       = ptr;
    assign bus.FRAME_ERR = frame_err;
    assign bus.CPU_RSTN  = cpu_rstn_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.CHK_ERR   = chk_err_q;
endmodule
